display_scanner: RTL and testbench

- Time-multiplexes a DIGITS-wide hex value onto one shared 7-segment decoder.
- Sits directly upstream of the hex-to-7-segment decoder. Drives its 4-bit input one nibble at a time and produces one-hot digit enables for the common-anode/cathode drivers.
- Adds a per-slot ghost-blanking gap, optional leading-zero suppression, and tear-free value updates at frame boundaries.

---
 rtl/display_scanner.sv | 127 ++++++++++++
 tb/tb_display_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Time-multiplexes a DIGITS-wide hex value onto one shared 7-segment decoder,
// with per-slot ghost-blanking, leading-zero suppression and frame-aligned updates.
module display_scanner #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [4*DIGITS-1:0]                     value,
  input  logic                                    load,
  input  logic                                    blank_leading,
  output logic [3:0]                              nibble,
  output logic [DIGITS-1:0]                       digit_en,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
  output logic                                    frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam int DW = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {
    GAP  = 1'b0,
    SCAN = 1'b1
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     pending_q, pending_d;
  logic [DW-1:0]     display_q, display_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic [IW-1:0]     digit_idx_q, digit_idx_d;
  logic              frame_done_q, frame_done_d;

  logic              boundary;
  logic              all_zero;
  logic [DIGITS-1:0] blanked;
  int unsigned       di;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = load ? value : pending_q;
    boundary  = (phase_q == SCAN) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    display_d = boundary ? (load ? value : pending_q) : display_q;

    if (!enable) begin
      phase_d = GAP;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (phase_q)
        GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) phase_d = SCAN;
        end
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = GAP;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: phase_d = GAP;
      endcase
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    all_zero = 1'b1;
    blanked  = '0;
    di       = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      di = DIGITS - 1 - k;
      all_zero = all_zero && (display_d[4*di +: 4] == 4'h0);
      blanked[di] = blank_leading && all_zero && (di != 0);
    end

    nibble_d     = display_d[4*int'(idx_d) +: 4];
    digit_idx_d  = idx_d;
    digit_en_d   = '0;
    if ((phase_d == SCAN) && !blanked[idx_d]) digit_en_d = DIGITS'(1) << idx_d;
    frame_done_d = (phase_d == SCAN) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      display_q    <= '0;
      nibble_q     <= '0;
      digit_en_q   <= '0;
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_en   = digit_en_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed test-plan steps plus random
// traffic, checked every cycle against a time-position reference model.
module tb_display_scanner;

  localparam int D     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = D * P;

  logic        clk = 1'b0;
  logic        reset, enable, load, blank_leading;
  logic [15:0] value;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: t = cycles since the scan (re)started; everything else
  // follows from t by division/modulo.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic        m_bl;
  logic        cur_bl;

  display_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .load(load),
    .blank_leading(blank_leading), .nibble(nibble), .digit_en(digit_en),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input int tt);
    return (tt / P) % D;
  endfunction

  function automatic logic [3:0] exp_en(input int tt);
    int s;
    logic lead;
    s = slot_of(tt);
    if ((tt % P) < B) return 4'b0000;
    lead = (s != 0) && m_bl;
    for (int j = s; j < D; j++) if (m_disp[4*j +: 4] != 4'h0) lead = 1'b0;
    if (lead) return 4'b0000;
    return 4'(1 << s);
  endfunction

  task automatic cyc(input logic e, input logic l, input logic [15:0] v,
                     input logic b, input logic r);
    reset = r; enable = e; load = l; value = v; blank_leading = b;
    @(posedge clk);
    if (r) begin
      t = 0; m_disp = '0; m_pend = '0;
    end else begin
      if ((t % FRAME) == FRAME - 1) m_disp = l ? v : m_pend;
      if (l) m_pend = v;
      t = e ? t + 1 : 0;
    end
    m_bl = b;
    #1;
    chk("nibble",     32'(nibble),     32'(m_disp[4*slot_of(t) +: 4]));
    chk("digit_en",   32'(digit_en),   32'(exp_en(t)));
    chk("digit_idx",  32'(digit_idx),  32'(slot_of(t)));
    chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 16'($urandom), cur_bl, 1'b0);
  endtask

  task automatic run_to(input int pos);
    int k;
    for (k = 0; k < 4 * FRAME; k++) begin
      if ((t % FRAME) == pos) break;
      cyc(1'b1, 1'b0, 16'($urandom), cur_bl, 1'b0);
    end
    chk("run_to_bound", 32'(k < 4 * FRAME), 32'd1);
  endtask

  task automatic show(input logic [15:0] v);
    cyc(1'b1, 1'b1, v, cur_bl, 1'b0);
    run_to(FRAME - 1);
    idle(1);
  endtask

  initial begin
    t = 0; m_disp = '0; m_pend = '0; m_bl = 1'b0; cur_bl = 1'b0;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; blank_leading = 1'b0;

    // 1: reset, load 1234, scan it out
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("reset_outputs", {nibble, digit_en, 2'(digit_idx), 3'(frame_done)}, '0);
    show(16'h1234);
    chk("t1_slot0_gap_nib", 32'(nibble), 32'h4);
    chk("t1_slot0_gap_en", 32'(digit_en), 32'h0);
    idle(2);
    chk("t1_slot0_scan_en", 32'(digit_en), 32'h1);
    run_to(FRAME - 1);
    chk("t1_frame_done", 32'(frame_done), 32'h1);
    chk("t1_slot3_nib", 32'(nibble), 32'h1);
    idle(FRAME);

    // 2: leading-zero suppression
    cur_bl = 1'b1;
    show(16'h0050);
    idle(FRAME);
    show(16'h0000);
    idle(FRAME);
    cur_bl = 1'b0;
    idle(FRAME);

    // 3: load mid-frame does not tear the current frame
    show(16'h1234);
    run_to(P + 3);
    cyc(1'b1, 1'b1, 16'hABCD, cur_bl, 1'b0);
    run_to(2 * P + 4);
    chk("t3_slot2_old", 32'(nibble), 32'h2);
    run_to(0);
    idle(1);
    chk("t3_new_frame", 32'(nibble), 32'hD);

    // 4: load in the frame_done cycle bypasses to display
    run_to(FRAME - 1);
    cyc(1'b1, 1'b1, 16'h5678, cur_bl, 1'b0);
    chk("t4_bypass", 32'(nibble), 32'h8);
    run_to(12);
    cyc(1'b1, 1'b1, 16'h9999, cur_bl, 1'b0);
    run_to(FRAME - 2);
    chk("t4_no_early", 32'(nibble), 32'h5);
    idle(2);
    chk("t4_next_frame", 32'(nibble), 32'h9);

    // 5: enable drop mid-scan of slot 2, then restart
    run_to(2 * P + 4);
    cyc(1'b0, 1'b0, 16'h0, cur_bl, 1'b0);
    chk("t5_dark", {28'h0, digit_en}, 32'h0);
    chk("t5_idx0", 32'(digit_idx), 32'h0);
    cyc(1'b0, 1'b1, 16'h4321, cur_bl, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, cur_bl, 1'b0);
    idle(2);
    chk("t5_gap_then_scan", 32'(digit_en), 32'h1);

    // 6: reset mid-scan of slot 3
    show(16'hABCD);
    run_to(3 * P + 5);
    cyc(1'b1, 1'b0, 16'h0, cur_bl, 1'b1);
    chk("t6_reset_outputs", {nibble, digit_en, 2'(digit_idx), 3'(frame_done)}, '0);
    idle(FRAME + 4);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) cur_bl = ~cur_bl;
      cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
          cur_bl, ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
